// File: rtl/tx_fcs_insert.sv
// Appends the Ethernet CRC-32 FCS to an AXI-Stream frame, 32-bit datapath.
// FCS bytes fill the unused lanes of the last beat, and any leftover bytes go out in one tail word.
module tx_fcs_insert #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  o_keep_err
);

  typedef enum logic {PASS, TAIL} state_t;

  state_t                  state_reg, state_next;
  logic [31:0]             crc_reg;
  logic [DATA_WIDTH-1:0]   m_data_reg;
  logic [KEEP_WIDTH-1:0]   m_keep_reg;
  logic                    m_valid_reg, m_last_reg;
  logic [DATA_WIDTH-1:0]   tail_data_reg;
  logic [KEEP_WIDTH-1:0]   tail_keep_reg;
  logic                    keep_err_reg;

  logic                    out_free, s_hs, tail_load;
  logic [2:0]              k_last, k_eff;
  logic                    keep_ok;
  logic [31:0]             crc_chain [0:4];
  logic [31:0]             fcs;
  logic [5:0]              shift;
  logic [31:0]             lane_mask, out_word, tail_word;
  logic [3:0]              tail_keep;

  // Reflected CRC-32 update with one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    end
    return r;
  endfunction

  assign crc_chain[0] = crc_reg;
  for (genvar gi = 0; gi < 4; gi++) begin : g_crc_lane
    assign crc_chain[gi+1] = crc_byte(crc_chain[gi], s_axis_tdata[8*gi +: 8]);
  end

  always_comb begin
    k_last  = 3'd4;
    keep_ok = 1'b1;
    case (s_axis_tkeep)
      4'b0001: k_last = 3'd1;
      4'b0011: k_last = 3'd2;
      4'b0111: k_last = 3'd3;
      4'b1111: k_last = 3'd4;
      default: keep_ok = 1'b0;
    endcase
  end

  // Non-last beats always carry four bytes. With k = 4 the same shifts
  // yield the unmodified word and a full-FCS tail.
  always_comb begin
    k_eff     = s_axis_tlast ? k_last : 3'd4;
    fcs       = ~crc_chain[k_eff];
    shift     = {k_eff, 3'b000};
    lane_mask = 32'hFFFF_FFFF >> (6'd32 - shift);
    out_word  = (s_axis_tdata & lane_mask) | (fcs << shift);
    tail_word = fcs >> (6'd32 - shift);
    tail_keep = 4'b1111 >> (3'd4 - k_eff);
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state_reg <= PASS;
    else            state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      PASS: if (s_hs && s_axis_tlast) state_next = TAIL;
      TAIL: if (out_free)             state_next = PASS;
      default:                        state_next = PASS;
    endcase
  end

  // Output / control logic
  always_comb begin
    out_free      = !m_valid_reg || m_axis_tready;
    s_axis_tready = i_reset_n && (state_reg == PASS) && out_free;
    s_hs          = s_axis_tvalid && s_axis_tready;
    tail_load     = (state_reg == TAIL) && out_free;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      crc_reg       <= 32'hFFFF_FFFF;
      m_data_reg    <= '0;
      m_keep_reg    <= '0;
      m_valid_reg   <= 1'b0;
      m_last_reg    <= 1'b0;
      tail_data_reg <= '0;
      tail_keep_reg <= '0;
      keep_err_reg  <= 1'b0;
    end else begin
      keep_err_reg <= s_hs && s_axis_tlast && !keep_ok;
      if (s_hs) begin
        m_data_reg  <= out_word;
        m_keep_reg  <= 4'hF;
        m_last_reg  <= 1'b0;
        m_valid_reg <= 1'b1;
        crc_reg     <= s_axis_tlast ? 32'hFFFF_FFFF : crc_chain[4];
        if (s_axis_tlast) begin
          tail_data_reg <= tail_word;
          tail_keep_reg <= tail_keep;
        end
      end else if (tail_load) begin
        m_data_reg  <= tail_data_reg;
        m_keep_reg  <= tail_keep_reg;
        m_last_reg  <= 1'b1;
        m_valid_reg <= 1'b1;
      end else if (m_axis_tready) begin
        m_valid_reg <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = m_data_reg;
  assign m_axis_tkeep  = m_keep_reg;
  assign m_axis_tvalid = m_valid_reg;
  assign m_axis_tlast  = m_last_reg;
  assign o_keep_err    = keep_err_reg;

endmodule

// File: tb/tb_tx_fcs_insert.sv
// Directed and random-frame bench for tx_fcs_insert; outputs are checked against a byte-level CRC-32 model.
module tb_tx_fcs_insert;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic [3:0]  s_axis_tkeep = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic        o_keep_err;

  tx_fcs_insert dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .o_keep_err(o_keep_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;
  typedef logic [7:0] byte_q_t[$];

  beat_t in_q[$], exp_q[$], out_q[$];
  int    total = 0, bad = 0, keep_err_cnt = 0;
  bit    bp_rand = 0, stall = 0;
  logic        cap_valid, cap_last, cap_sready, cap_err;
  logic [31:0] cap_data;
  logic [3:0]  cap_keep;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc32(input byte_q_t b);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i])
      for (int j = 0; j < 8; j++)
        c = (c[0] ^ b[i][j]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return ~c;
  endfunction

  // One clock: drive at negedge, sample 1 ns before posedge, commit handshakes at posedge.
  task automatic tick();
    bit acc_in, acc_out;
    beat_t cap;
    @(negedge i_clk);
    if (in_q.size() > 0) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = in_q[0].data;
      s_axis_tkeep  = in_q[0].keep;
      s_axis_tlast  = in_q[0].last;
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
    end
    m_axis_tready = stall ? 1'b0 : (bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    #4;
    cap_valid  = m_axis_tvalid;
    cap_data   = m_axis_tdata;
    cap_keep   = m_axis_tkeep;
    cap_last   = m_axis_tlast;
    cap_sready = s_axis_tready;
    cap_err    = o_keep_err;
    if (o_keep_err === 1'b1) keep_err_cnt++;
    acc_in  = s_axis_tvalid && (s_axis_tready === 1'b1);
    acc_out = (m_axis_tvalid === 1'b1) && m_axis_tready;
    cap = '{data: m_axis_tdata, keep: m_axis_tkeep, last: m_axis_tlast};
    @(posedge i_clk);
    if (acc_in) void'(in_q.pop_front());
    if (acc_out) out_q.push_back(cap);
  endtask

  task automatic push_in(input logic [31:0] d, input logic [3:0] k, input logic l);
    in_q.push_back('{data: d, keep: k, last: l});
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_q.push_back('{data: d, keep: k, last: l});
  endtask

  // Queue a frame as input words (junk in don't-care lanes) and, optionally, its expected output.
  task automatic add_frame(input byte_q_t b, input bit expect_out);
    byte_q_t all;
    logic [31:0] d, fcs;
    int n, nw, k;
    n  = b.size();
    nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      d = $urandom;
      for (int l = 0; l < 4; l++)
        if (4*w + l < n) d[8*l +: 8] = b[4*w + l];
      k = (w == nw - 1) ? n - 4*w : 4;
      if (w == nw - 1) push_in(d, 4'b1111 >> (4 - k), 1'b1);
      else             push_in(d, 4'($urandom_range(0, 15)), 1'b0);
    end
    if (!expect_out) return;
    fcs = crc32(b);
    all = b;
    for (int i = 0; i < 4; i++) all.push_back(fcs[8*i +: 8]);
    nw = (all.size() + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      d = '0;
      k = (w == nw - 1) ? all.size() - 4*w : 4;
      for (int l = 0; l < k; l++) d[8*l +: 8] = all[4*w + l];
      push_exp(d, 4'b1111 >> (4 - k), (w == nw - 1));
    end
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 20000;
    while ((in_q.size() > 0 || out_q.size() < exp_q.size()) && budget > 0) begin
      tick();
      budget--;
    end
    chk({tag, " timeout"}, 32'(budget > 0), 32'd1);
    repeat (4) tick();
  endtask

  task automatic compare(input string tag);
    int n;
    chk({tag, " count"}, out_q.size(), exp_q.size());
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s data[%0d]", tag, i), out_q[i].data, exp_q[i].data);
      chk($sformatf("%s keep[%0d]", tag, i), 32'(out_q[i].keep), 32'(exp_q[i].keep));
      chk($sformatf("%s last[%0d]", tag, i), 32'(out_q[i].last), 32'(exp_q[i].last));
    end
    $display("frame set %s: %0d words checked", tag, n);
    out_q.delete();
    exp_q.delete();
  endtask

  initial begin
    byte_q_t fb;
    logic [31:0] held;
    int budget, tails;

    // Reset state
    repeat (3) tick();
    chk("rst tready", 32'(cap_sready), 32'd0);
    chk("rst tvalid", 32'(cap_valid), 32'd0);
    chk("rst tdata", cap_data, 32'd0);
    chk("rst tkeep", 32'(cap_keep), 32'd0);
    chk("rst tlast", 32'(cap_last), 32'd0);
    chk("rst keep_err", 32'(cap_err), 32'd0);
    i_reset_n = 1'b1;
    tick();
    chk("release tready", 32'(cap_sready), 32'd1);

    // "123456789": FCS 0xCBF43926
    push_in(32'h34333231, 4'hF, 1'b0);
    push_in(32'h38373635, 4'hF, 1'b0);
    push_in(32'h00000039, 4'h1, 1'b1);
    push_exp(32'h34333231, 4'hF, 1'b0);
    push_exp(32'h38373635, 4'hF, 1'b0);
    push_exp(32'hF4392639, 4'hF, 1'b0);
    push_exp(32'h000000CB, 4'h1, 1'b1);
    drain("check9");
    compare("check9");

    // Single-beat all-zero frame
    push_in(32'h0, 4'hF, 1'b1);
    push_exp(32'h0, 4'hF, 1'b0);
    push_exp(32'h2144DF1C, 4'hF, 1'b1);
    drain("zero4");
    compare("zero4");

    // Illegal tkeep 0101 on the last beat: processed as four bytes
    keep_err_cnt = 0;
    push_in(32'h04030201, 4'b0101, 1'b1);
    fb = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_exp(32'h04030201, 4'hF, 1'b0);
    push_exp(crc32(fb), 4'hF, 1'b1);
    drain("badkeep");
    compare("badkeep");
    chk("badkeep pulses", keep_err_cnt, 32'd1);

    // Downstream stall of 5 cycles mid-frame
    fb.delete();
    for (int i = 0; i < 22; i++) fb.push_back(8'($urandom));
    add_frame(fb, 1'b1);
    budget = 200;
    while (out_q.size() < 2 && budget > 0) begin tick(); budget--; end
    chk("stall start", 32'(budget > 0), 32'd1);
    stall = 1;
    held  = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) held = cap_data;
      else chk($sformatf("stall hold[%0d]", i), cap_data, held);
      chk($sformatf("stall valid[%0d]", i), 32'(cap_valid), 32'd1);
      chk($sformatf("stall tready[%0d]", i), 32'(cap_sready), 32'd0);
    end
    stall = 0;
    drain("stall");
    compare("stall");

    // Reset in the middle of a frame, then the 9-byte frame again
    fb.delete();
    for (int i = 0; i < 24; i++) fb.push_back(8'($urandom));
    add_frame(fb, 1'b0);
    budget = 200;
    while (in_q.size() > 4 && budget > 0) begin tick(); budget--; end
    chk("midrst start", 32'(budget > 0), 32'd1);
    i_reset_n = 1'b0;
    in_q.delete();
    tick();
    chk("midrst tready", 32'(cap_sready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("midrst tvalid[%0d]", i), 32'(cap_valid), 32'd0);
    end
    out_q.delete();
    i_reset_n = 1'b1;
    push_in(32'h34333231, 4'hF, 1'b0);
    push_in(32'h38373635, 4'hF, 1'b0);
    push_in(32'h00000039, 4'h1, 1'b1);
    push_exp(32'h34333231, 4'hF, 1'b0);
    push_exp(32'h38373635, 4'hF, 1'b0);
    push_exp(32'hF4392639, 4'hF, 1'b0);
    push_exp(32'h000000CB, 4'h1, 1'b1);
    drain("postrst");
    compare("postrst");

    // Random back-to-back frames under random backpressure
    keep_err_cnt = 0;
    bp_rand = 1;
    for (int f = 0; f < 21; f++) begin
      fb.delete();
      for (int i = 0, n = (f == 20) ? 1500 : $urandom_range(1, 48); i < n; i++)
        fb.push_back(8'($urandom));
      add_frame(fb, 1'b1);
    end
    drain("random");
    tails = 0;
    foreach (out_q[i]) if (out_q[i].last) tails++;
    chk("random tails", tails, 32'd21);
    compare("random");
    chk("random keep_err", keep_err_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
